filter_frame_ctrl: RTL and testbench
====================================

// Module: filter_frame_ctrl
// PURPOSE
//  Frame-synchronous controller for the 3x3 RGB565 filter path. Accepts filter-mode
//  requests, applies them only at frame start, tracks pixel/line position, and emits a
//  border flag aligned with the filter output stream. Sits beside the linebuffer-based
//  filters and drives the output mux select and border blanking.
// PARAMETERS
//  H_ACTIVE        480  active pixels per line
//  V_ACTIVE        272  active lines per frame
//  FILTER_LATENCY  2    clocks from in_de to filter out_de; border flag is delayed to match
// PORTS
//  clk         in   1     pixel clock, single domain
//  rst         in   1     asynchronous, active-high reset
//  cfg_mode    in   2     requested mode (filter_pkg::filt_mode_t)
//  cfg_valid   in   1     request valid
//  cfg_ready   out  1     high when no request is pending
//  in_hs       in   1     input HS
//  in_vs       in   1     input VS, active-high; frame start = rising edge
//  in_de       in   1     input DE
//  sel_mode    out  2     mode applied to the current frame (mux select)
//  mode_done   out  1     1-clk pulse when a pending mode is applied
//  x_cnt       out  9     pixel index within the current line (in_de domain, no delay)
//  y_cnt       out  9     line index within the current frame
//  out_border  out  1     delayed DE AND (x==0 | x==H_ACTIVE-1 | y==0 | y==V_ACTIVE-1)
//  frame_cnt   out  8     frames seen since reset, wraps 255->0
//  err_hlen    out  1     sticky: a line ended with x count != H_ACTIVE
// BEHAVIOUR
//  Reset: sel_mode=MODE_BYPASS, cfg_ready=1, mode_done=0, x_cnt=0, y_cnt=0,
//   out_border=0, frame_cnt=0, err_hlen=0, pending=0, all delay stages 0.
//  Edge detect: vs_rise = in_vs & ~vs_q; de_fall = ~in_de & de_q (registered _q copies).
//  Handshake: transfer when cfg_valid & cfg_ready; cfg_mode latched into pend_mode,
//   pending<=1, cfg_ready<=0 next clock. cfg_valid while cfg_ready=0 is ignored (no drop
//   error, requester must hold). Request modes are registered, never combinationally passed.
//  FSM (2 states): IDLE (pending=0, cfg_ready=1) -> PEND on transfer;
//   PEND -> IDLE on vs_rise: sel_mode<=pend_mode, mode_done=1 for 1 clk, cfg_ready<=1.
//  Simultaneous transfer and vs_rise in IDLE: request is latched, applied at NEXT vs_rise.
//  vs_rise in PEND with equal mode still pulses mode_done.
//  sel_mode never changes except on a vs_rise clock -> no mid-frame mode change.
//  x_cnt: +1 each in_de clock (x_cnt shows index of current pixel, 0 on first DE clock);
//   cleared on de_fall; saturates at 511.
//  y_cnt: +1 on de_fall, cleared on vs_rise; saturates at 511.
//  err_hlen: set on de_fall when counted pixels != H_ACTIVE; cleared only by rst.
//  frame_cnt: +1 on vs_rise, wraps.
//  Border: {in_de, edge_hit} pushed through FILTER_LATENCY-stage shift register;
//   out_border = stage[FILTER_LATENCY-1], so it coincides with filter out_de. Lines
//   beyond V_ACTIVE are not flagged (y compare is exact).
//  in_hs is only registered for alignment (not used in counting); DE is authoritative.
//  Reset mid-frame: everything returns to reset values; first frame after reset runs
//   in BYPASS until a request is applied at a vs_rise.
// STRUCTURE
//  filter_pkg: typedef enum logic[1:0] filt_mode_t {MODE_BYPASS=0, MODE_GAUSS=1,
//   MODE_MEDIAN=2, MODE_SOBEL=3}; localparam CNT_W=9.
//  Sub-module sync_delay #(WIDTH, DEPTH): async-reset shift register, used for the
//   border/DE pipeline (DEPTH=FILTER_LATENCY, WIDTH=2).
// TESTING
//  1 Reset then 2 frames of 480x272, no request -> sel_mode=0, frame_cnt=2, err_hlen=0.
//  2 cfg_mode=1 valid mid-frame -> cfg_ready=0 next clk; at next vs_rise sel_mode=1,
//    mode_done 1 clk, cfg_ready=1; sel_mode stable through rest of frame.
//  3 Request transfer on the same clock as vs_rise -> sel_mode unchanged this frame,
//    applied at the following vs_rise.
//  4 Border: FILTER_LATENCY=2, line 5 -> out_border high only on delayed pixels 0 and 479;
//    lines 0 and 271 fully high; low whenever delayed DE is low.
//  5 One line of 479 DE clocks -> err_hlen=1 after its de_fall, stays 1 over later frames.
//  6 rst asserted mid-line with pending=1 -> outputs at reset values asynchronously;
//    pending request discarded, sel_mode=0 after release.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and helpers for the RGB565 3x3 filter control path.
package filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GAUSS  = 2'd1,
    MODE_MEDIAN = 2'd2,
    MODE_SOBEL  = 2'd3
  } filt_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ctrl_state_t;

  localparam int CNT_W = 9;

  // Position counters stick at all-ones instead of wrapping on oversized frames.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Asynchronous-reset shift register: o_q is i_d delayed by DEPTH clocks.
module sync_delay #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame-synchronous mode controller: applies mode requests at VS rise, tracks pixel
// position and produces a border flag aligned with the filter output DE.
module filter_frame_ctrl
  import filter_pkg::*;
#(
  parameter int H_ACTIVE       = 480,
  parameter int V_ACTIVE       = 272,
  parameter int FILTER_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic             in_de,
  output logic [1:0]       sel_mode,
  output logic             mode_done,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] y_cnt,
  output logic             out_border,
  output logic [7:0]       frame_cnt,
  output logic             err_hlen
);

  localparam logic [CNT_W-1:0] X_LEN  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  ctrl_state_t      r_state, w_state_nxt;
  filt_mode_t       r_pend_mode, r_sel_mode;
  logic             r_mode_done;
  logic             r_vs_q, r_de_q, r_hs_q;
  logic [CNT_W-1:0] r_x, r_y;
  logic [7:0]       r_frame;
  logic             r_err;
  logic             w_vs_rise, w_de_fall, w_accept, w_apply, w_edge_hit;
  logic [1:0]       w_border_dly;
  logic             w_unused_hs;

  assign w_vs_rise   = in_vs & ~r_vs_q;
  assign w_de_fall   = ~in_de & r_de_q;
  // HS is kept registered for alignment only; DE drives all counting.
  assign w_unused_hs = r_hs_q;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: if (cfg_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_PEND;
      end
      ST_PEND: if (w_vs_rise) begin
        w_apply     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A request arriving on the VS-rise clock lands in PEND and waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pend_mode <= MODE_BYPASS;
      r_sel_mode  <= MODE_BYPASS;
      r_mode_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_done <= w_apply;
      if (w_accept) r_pend_mode <= filt_mode_t'(cfg_mode);
      if (w_apply)  r_sel_mode  <= r_pend_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_q  <= 1'b0;
      r_de_q  <= 1'b0;
      r_hs_q  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
      r_err   <= 1'b0;
    end else begin
      r_vs_q <= in_vs;
      r_de_q <= in_de;
      r_hs_q <= in_hs;
      if (in_de)          r_x <= sat_inc(r_x);
      else if (w_de_fall) r_x <= '0;
      if (w_vs_rise)      r_y <= '0;
      else if (w_de_fall) r_y <= sat_inc(r_y);
      if (w_vs_rise)      r_frame <= r_frame + 8'd1;
      if (w_de_fall && (r_x != X_LEN)) r_err <= 1'b1;
    end
  end

  assign w_edge_hit = (r_x == '0) | (r_x == X_LAST) | (r_y == '0) | (r_y == Y_LAST);

  sync_delay #(
    .WIDTH (2),
    .DEPTH (FILTER_LATENCY)
  ) u_border_dly (
    .clk (clk),
    .rst (rst),
    .i_d ({in_de, w_edge_hit}),
    .o_q (w_border_dly)
  );

  assign out_border = w_border_dly[1] & w_border_dly[0];
  assign cfg_ready  = (r_state == ST_IDLE);
  assign sel_mode   = r_sel_mode;
  assign mode_done  = r_mode_done;
  assign x_cnt      = r_x;
  assign y_cnt      = r_y;
  assign frame_cnt  = r_frame;
  assign err_hlen   = r_err;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Self-checking bench for filter_frame_ctrl: frame table plus border scoreboard.
module tb_filter_frame_ctrl;

  localparam int H   = 480;
  localparam int V   = 8;
  localparam int LAT = 2;

  typedef struct {
    bit         reqMid;
    logic [1:0] reqMode;
    bit         reqAtVs;
    logic [1:0] reqVsMode;
    bit         shortLine;
    logic [1:0] expSel;
    bit         expDone;
    logic [7:0] expFrames;
    bit         expErr;
  } frameVec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfgMode;
  logic       cfgValid, cfgReady;
  logic       inHs, inVs, inDe;
  logic [1:0] selMode;
  logic       modeDone;
  logic [8:0] xCnt, yCnt;
  logic       outBorder;
  logic [7:0] frameCnt;
  logic       errHlen;

  int checks = 0;
  int errors = 0;
  bit sbEn   = 1'b0;
  bit sbQ[$];
  frameVec_t vecs[10];

  always #5 clk = ~clk;

  filter_frame_ctrl #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .FILTER_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_mode   (cfgMode),
    .cfg_valid  (cfgValid),
    .cfg_ready  (cfgReady),
    .in_hs      (inHs),
    .in_vs      (inVs),
    .in_de      (inDe),
    .sel_mode   (selMode),
    .mode_done  (modeDone),
    .x_cnt      (xCnt),
    .y_cnt      (yCnt),
    .out_border (outBorder),
    .frame_cnt  (frameCnt),
    .err_hlen   (errHlen)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the expected border for this input clock joins the scoreboard.
  task automatic applyStimulus(input logic vs, input logic de, input logic valid,
                               input logic [1:0] mode, input bit expBorder);
    @(posedge clk);
    #1;
    inVs     = vs;
    inDe     = de;
    inHs     = de;
    cfgValid = valid;
    cfgMode  = mode;
    if (sbEn) sbQ.push_back(expBorder);
  endtask

  // The border for an input clock must appear LAT clocks later.
  always @(negedge clk) begin
    bit e;
    if (sbEn && sbQ.size() > LAT) begin
      e = sbQ.pop_front();
      checkOutput("out_border", 32'(outBorder), 32'(e));
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " sel_mode"},   32'(selMode),   0);
    checkOutput({tag, " cfg_ready"},  32'(cfgReady),  1);
    checkOutput({tag, " mode_done"},  32'(modeDone),  0);
    checkOutput({tag, " x_cnt"},      32'(xCnt),      0);
    checkOutput({tag, " y_cnt"},      32'(yCnt),      0);
    checkOutput({tag, " out_border"}, 32'(outBorder), 0);
    checkOutput({tag, " frame_cnt"},  32'(frameCnt),  0);
    checkOutput({tag, " err_hlen"},   32'(errHlen),   0);
  endtask

  task automatic runFrame(input frameVec_t v);
    int  len;
    bit  req, bord, doSample;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, v.reqAtVs, v.reqVsMode, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("sel_mode at frame start", 32'(selMode), 32'(v.expSel));
    checkOutput("mode_done at frame start", 32'(modeDone), 32'(v.expDone));
    checkOutput("frame_cnt", 32'(frameCnt), 32'(v.expFrames));
    checkOutput("y_cnt after vs", 32'(yCnt), 0);
    checkOutput("cfg_ready at frame start", 32'(cfgReady), v.reqAtVs ? 0 : 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("mode_done pulse width", 32'(modeDone), 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int ln = 0; ln < V; ln++) begin
      len = (v.shortLine && ln == 3) ? H - 1 : H;
      for (int px = 0; px < len; px++) begin
        req  = v.reqMid && ln == 2 && px == 10;
        bord = (px == 0) || (px == H - 1) || (ln == 0) || (ln == V - 1);
        applyStimulus(1'b0, 1'b1, req, v.reqMode, bord);
        doSample = (px == 0) || (px == len - 1) || (v.reqMid && ln == 2 && (px == 10 || px == 11));
        if (doSample) begin
          @(negedge clk);
          if (px == 0 || px == len - 1) checkOutput("x_cnt", 32'(xCnt), px);
          if (px == 0) begin
            checkOutput("y_cnt", 32'(yCnt), ln);
            checkOutput("sel_mode mid frame", 32'(selMode), 32'(v.expSel));
          end
          if (v.reqMid && ln == 2 && px == 10) checkOutput("cfg_ready before request", 32'(cfgReady), 1);
          if (v.reqMid && ln == 2 && px == 11) checkOutput("cfg_ready after request", 32'(cfgReady), 0);
        end
      end
      for (int b = 0; b < 6; b++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        if (v.shortLine && ln == 3 && b == 2) begin
          @(negedge clk);
          checkOutput("err_hlen after short line", 32'(errHlen), 1);
        end
      end
    end
    @(negedge clk);
    checkOutput("sel_mode end of frame", 32'(selMode), 32'(v.expSel));
    checkOutput("err_hlen end of frame", 32'(errHlen), 32'(v.expErr));
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 8'd1,  1'b0};
    vecs[1] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 8'd2,  1'b0};
    vecs[2] = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 8'd3,  1'b0};
    vecs[3] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 8'd4,  1'b0};
    vecs[4] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd1, 1'b0, 8'd5,  1'b0};
    vecs[5] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 8'd6,  1'b0};
    vecs[6] = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 8'd7,  1'b0};
    vecs[7] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 8'd8,  1'b0};
    vecs[8] = '{1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 8'd9,  1'b1};
    vecs[9] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1, 8'd10, 1'b1};

    rst = 1'b1; inVs = 1'b0; inDe = 1'b0; inHs = 1'b0; cfgValid = 1'b0; cfgMode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("power-on reset");
    @(posedge clk);
    #1;
    rst  = 1'b0;
    sbEn = 1'b1;

    foreach (vecs[i]) runFrame(vecs[i]);

    // Reset in the middle of a line while a SOBEL request is pending.
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int px = 0; px < 100; px++)
      applyStimulus(1'b0, 1'b1, px == 5, 2'd3, 1'b1);
    @(negedge clk);
    checkOutput("cfg_ready pending before reset", 32'(cfgReady), 0);
    checkOutput("x_cnt before reset", 32'(xCnt), 99);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    #2;
    rst = 1'b1;
    sbQ.delete();
    inDe = 1'b0;
    #1;
    checkResetValues("async reset mid-line");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    runFrame('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 8'd1, 1'b0});
    runFrame('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 8'd2, 1'b0});

    repeat (LAT + 2) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    sbEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
